// File: rtl/instr_decode_stage.sv
// Single-register RV32I/RV32M decode stage: classifies the opcode, builds the sign-extended
// immediate and flags unsupported encodings, with one valid/ready output register.
module instr_decode_stage #(
    parameter int XLEN  = 32,
    parameter int EN_M  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  pc_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [4:0]       rs1_addr_o,
    output logic [4:0]       rs2_addr_o,
    output logic [4:0]       rd_addr_o,
    output logic [6:0]       opcode_o,
    output logic [2:0]       funct3_o,
    output logic [6:0]       funct7_o,
    output logic [XLEN-1:0]  imm_o,
    output logic [2:0]       imm_type_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] dec_count_o
);

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    logic               capture;
    logic [6:0]         op;
    logic [6:0]         f7;
    logic [2:0]         d_type;
    logic               d_ill;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]    d_imm;

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
    // the register accepts whenever it is empty or is being drained in the same cycle.
    assign in_ready_o = !out_valid_o || out_ready_i;
    assign capture    = in_valid_i && in_ready_o && !flush_i;

    assign op    = instr_i[6:0];
    assign f7    = instr_i[31:25];
    assign d_imm = XLEN'(imm32);

    always_comb begin
        d_type = IMM_NONE;
        d_ill  = 1'b0;
        imm32  = '0;
        case (op)
            7'b0110011: begin
                d_ill = !((f7 == 7'b0000000) || (f7 == 7'b0100000) ||
                          ((EN_M != 0) && (f7 == 7'b0000001)));
            end
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                d_type = IMM_I;
                imm32  = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            7'b0100011: begin
                d_type = IMM_S;
                imm32  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            7'b1100011: begin
                d_type = IMM_B;
                imm32  = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                d_type = IMM_U;
                imm32  = {instr_i[31:12], 12'b0};
            end
            7'b1101111: begin
                d_type = IMM_J;
                imm32  = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            end
            default: d_ill = 1'b1;
        endcase
        if (instr_i[1:0] != 2'b11) d_ill = 1'b1;
        // Illegal encodings keep their raw fields but carry no immediate.
        if (d_ill) begin
            d_type = IMM_NONE;
            imm32  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            pc_o        <= '0;
            rs1_addr_o  <= '0;
            rs2_addr_o  <= '0;
            rd_addr_o   <= '0;
            opcode_o    <= '0;
            funct3_o    <= '0;
            funct7_o    <= '0;
            imm_o       <= '0;
            imm_type_o  <= '0;
            illegal_o   <= 1'b0;
            dec_count_o <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (capture) begin
            out_valid_o <= 1'b1;
            pc_o        <= pc_i;
            rs1_addr_o  <= instr_i[19:15];
            rs2_addr_o  <= instr_i[24:20];
            rd_addr_o   <= instr_i[11:7];
            opcode_o    <= op;
            funct3_o    <= instr_i[14:12];
            funct7_o    <= f7;
            imm_o       <= d_imm;
            imm_type_o  <= d_type;
            illegal_o   <= d_ill;
            dec_count_o <= dec_count_o + CNT_W'(1);
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: scenario tasks plus a scoreboard that compares every
// drained bundle of the default instance against an independently derived expectation.
module tb_instr_decode_stage;

    localparam int W = 116;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] instr, pc;

    logic        in_ready, out_valid, illegal;
    logic [31:0] pc_o, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3, imm_type;
    logic [15:0] count;

    logic        m_in_ready, m_out_valid, m_illegal;
    logic [31:0] m_pc_o, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [6:0]  m_opcode, m_funct7;
    logic [2:0]  m_funct3, m_imm_type;
    logic [15:0] m_count;

    logic        w_in_ready, w_out_valid, w_illegal;
    logic [63:0] w_pc_o, w_imm;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [6:0]  w_opcode, w_funct7;
    logic [2:0]  w_funct3, w_imm_type;
    logic [1:0]  w_count;

    instr_decode_stage #(.XLEN(32), .EN_M(0), .CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .instr_i(instr), .pc_i(pc), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .pc_o(pc_o), .rs1_addr_o(rs1), .rs2_addr_o(rs2),
        .rd_addr_o(rd), .opcode_o(opcode), .funct3_o(funct3), .funct7_o(funct7),
        .imm_o(imm), .imm_type_o(imm_type), .illegal_o(illegal), .dec_count_o(count));

    instr_decode_stage #(.XLEN(32), .EN_M(1), .CNT_W(16)) dut_m (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(m_in_ready), .instr_i(instr), .pc_i(pc), .out_valid_o(m_out_valid),
        .out_ready_i(out_ready), .pc_o(m_pc_o), .rs1_addr_o(m_rs1), .rs2_addr_o(m_rs2),
        .rd_addr_o(m_rd), .opcode_o(m_opcode), .funct3_o(m_funct3), .funct7_o(m_funct7),
        .imm_o(m_imm), .imm_type_o(m_imm_type), .illegal_o(m_illegal), .dec_count_o(m_count));

    instr_decode_stage #(.XLEN(64), .EN_M(0), .CNT_W(2)) dut64 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(w_in_ready), .instr_i(instr), .pc_i({32'h0, pc}), .out_valid_o(w_out_valid),
        .out_ready_i(out_ready), .pc_o(w_pc_o), .rs1_addr_o(w_rs1), .rs2_addr_o(w_rs2),
        .rd_addr_o(w_rd), .opcode_o(w_opcode), .funct3_o(w_funct3), .funct7_o(w_funct7),
        .imm_o(w_imm), .imm_type_o(w_imm_type), .illegal_o(w_illegal), .dec_count_o(w_count));

    logic [W-1:0] exp_q[$];
    logic [15:0]  exp_cnt;
    logic [31:0]  last_pc;
    int           n_tests = 0;
    int           n_fail  = 0;

    function automatic logic [W-1:0] model(input logic [31:0] ins, input logic [31:0] p,
                                           input logic [15:0] cnt);
        logic [2:0]  t;
        logic        ill;
        logic [31:0] im;
        t = 3'd0; ill = 1'b0; im = 32'h0;
        case (ins[6:0])
            7'h33: ill = !(ins[31:25] == 7'h00 || ins[31:25] == 7'h20);
            7'h13, 7'h03, 7'h67, 7'h73: begin t = 3'd1; im = {{20{ins[31]}}, ins[31:20]}; end
            7'h23: begin t = 3'd2; im = {{20{ins[31]}}, ins[31:25], ins[11:7]}; end
            7'h63: begin t = 3'd3; im = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; end
            7'h37, 7'h17: begin t = 3'd4; im = {ins[31:12], 12'h000}; end
            7'h6f: begin t = 3'd5; im = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; end
            default: ill = 1'b1;
        endcase
        if (ins[1:0] != 2'b11) ill = 1'b1;
        if (ill) begin t = 3'd0; im = 32'h0; end
        return {p, ins[11:7], ins[19:15], ins[24:20], ins[6:0], ins[14:12], ins[31:25],
                im, t, ill, cnt};
    endfunction

    // Scoreboard: every bundle leaving the default instance is checked in order.
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got bundle pc=%h with empty expected queue", pc_o);
            end else begin
                logic [W-1:0] e, g;
                e = exp_q.pop_front();
                g = {pc_o, rd, rs1, rs2, opcode, funct3, funct7, imm, imm_type, illegal, count};
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL sb_bundle: got %h required %h", g, e);
                end
            end
        end
    end

    // Presents one instruction until it is accepted; inputs change 1 time unit after posedge.
    task automatic send(input logic [31:0] ins, input logic [31:0] p);
        bit done = 0;
        in_valid = 1'b1; instr = ins; pc = p;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                exp_cnt = exp_cnt + 16'd1;
                exp_q.push_back(model(ins, p, exp_cnt));
                last_pc = p;
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: instr %h never accepted", ins);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = 32'h0; pc = 32'h0; exp_cnt = 16'd0; last_pc = 32'h0;
        #12;
        n_tests++;
        if (out_valid !== 1'b0 || count !== 16'd0 || pc_o !== 32'h0 || imm !== 32'h0 ||
            in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b count=%0d pc=%h imm=%h ready=%b required 0 0 0 0 1",
                     out_valid, count, pc_o, imm, in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(32'hFFF10093, 32'h100);
        n_tests++;
        if (out_valid !== 1'b1 || rd !== 5'd1 || rs1 !== 5'd2 || imm !== 32'hFFFFFFFF ||
            imm_type !== 3'd1 || pc_o !== 32'h100 || count !== 16'd1 || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL addi: valid=%b rd=%0d rs1=%0d imm=%h type=%0d pc=%h cnt=%0d ill=%b required 1 1 2 ffffffff 1 100 1 0",
                     out_valid, rd, rs1, imm, imm_type, pc_o, count, illegal);
        end
        n_tests++;
        if (w_imm !== 64'hFFFFFFFFFFFFFFFF || w_pc_o !== 64'h100) begin
            n_fail++;
            $display("FAIL addi_xlen64: imm=%h pc=%h required ffffffffffffffff 100", w_imm, w_pc_o);
        end
    endtask

    task automatic test_wrap();
        send(32'h00500113, 32'h104);
        send(32'h00112223, 32'h108);
        send(32'h008000EF, 32'h10C);
        send(32'h40208033, 32'h110);
        n_tests++;
        if (w_count !== 2'd1 || count !== 16'd5) begin
            n_fail++;
            $display("FAIL count_wrap: cnt2=%0d cnt16=%0d required 1 5", w_count, count);
        end
    endtask

    task automatic test_imm();
        send(32'hFE208EE3, 32'h200);
        n_tests++;
        if (imm !== 32'hFFFFFFFC || imm_type !== 3'd3 || rs1 !== 5'd1 || rs2 !== 5'd2) begin
            n_fail++;
            $display("FAIL beq: imm=%h type=%0d rs1=%0d rs2=%0d required fffffffc 3 1 2",
                     imm, imm_type, rs1, rs2);
        end
        send(32'h123452B7, 32'h204);
        n_tests++;
        if (imm !== 32'h12345000 || imm_type !== 3'd4 || rd !== 5'd5) begin
            n_fail++;
            $display("FAIL lui: imm=%h type=%0d rd=%0d required 12345000 4 5", imm, imm_type, rd);
        end
        send(32'hFE112E23, 32'h208);
        send(32'h800000EF, 32'h20C);
        send(32'h00002017, 32'h210);
    endtask

    task automatic test_illegal();
        send(32'h00000000, 32'h300);
        n_tests++;
        if (illegal !== 1'b1 || imm !== 32'h0 || imm_type !== 3'd0) begin
            n_fail++;
            $display("FAIL illegal_zero: ill=%b imm=%h type=%0d required 1 0 0", illegal, imm, imm_type);
        end
        send(32'h022081B3, 32'h304);
        n_tests++;
        if (illegal !== 1'b1 || m_illegal !== 1'b0 || m_imm_type !== 3'd0 || m_rd !== 5'd3 ||
            funct7 !== 7'h01) begin
            n_fail++;
            $display("FAIL mul_en_m: ill=%b ill_m=%b type_m=%0d rd_m=%0d f7=%h required 1 0 0 3 01",
                     illegal, m_illegal, m_imm_type, m_rd, funct7);
        end
        send(32'hFFF10092, 32'h308);
    endtask

    task automatic test_stall();
        logic [31:0] held_pc;
        held_pc = last_pc;
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00A00513; pc = 32'h400;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || pc_o !== held_pc || count !== exp_cnt) begin
                n_fail++;
                $display("FAIL stall_hold: ready=%b valid=%b pc=%h cnt=%0d required 0 1 %h %0d",
                         in_ready, out_valid, pc_o, count, held_pc, exp_cnt);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(32'h00A00513, 32'h400);
        n_tests++;
        if (out_valid !== 1'b1 || pc_o !== 32'h400 || count !== exp_cnt) begin
            n_fail++;
            $display("FAIL back_to_back: valid=%b pc=%h cnt=%0d required 1 400 %0d",
                     out_valid, pc_o, count, exp_cnt);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        flush = 1'b1; in_valid = 1'b1; instr = 32'h00100093; pc = 32'h500;
        @(posedge clk); #1;
        exp_q.delete();
        n_tests++;
        if (out_valid !== 1'b0 || count !== exp_cnt) begin
            n_fail++;
            $display("FAIL flush_held: valid=%b cnt=%0d required 0 %0d", out_valid, count, exp_cnt);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0 || count !== exp_cnt) begin
            n_fail++;
            $display("FAIL flush_wins: valid=%b cnt=%0d required 0 %0d", out_valid, count, exp_cnt);
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(32'h00C00613, 32'h600);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_cnt = 16'd0;
        n_tests++;
        if (out_valid !== 1'b0 || count !== 16'd0 || pc_o !== 32'h0 || imm !== 32'h0 ||
            rd !== 5'd0 || w_count !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_async: valid=%b cnt=%0d pc=%h imm=%h rd=%0d required all 0",
                     out_valid, count, pc_o, imm, rd);
        end
        @(posedge clk); #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(32'h00C00613, 32'h604);
        n_tests++;
        if (out_valid !== 1'b1 || count !== 16'd1 || pc_o !== 32'h604) begin
            n_fail++;
            $display("FAIL after_reset: valid=%b cnt=%0d pc=%h required 1 1 604", out_valid, count, pc_o);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [11];
        logic [31:0] ins;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h5b};
        for (int c = 0; c < 300; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            ins = $urandom();
            if ($urandom_range(0, 3) == 0 && ops[$urandom_range(0, 10)] == 7'h33)
                ins[31:25] = 7'h20;
            ins[6:0] = ops[$urandom_range(0, 10)];
            instr = ins; pc = {$urandom_range(0, 16'hFFFF), 2'b00};
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_cnt = exp_cnt + 16'd1;
                exp_q.push_back(model(instr, pc, exp_cnt));
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
        end
        n_tests++;
        if (exp_q.size() != 0 || out_valid !== 1'b0 || count !== exp_cnt) begin
            n_fail++;
            $display("FAIL drain: left=%0d valid=%b cnt=%0d required 0 0 %0d",
                     exp_q.size(), out_valid, count, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_imm();
        test_illegal();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
